// File: rtl/ram_bus_pkg.sv
// Shared widths and initiator state encoding for the 10-bit / 16-bit register bus.
package ram_bus_pkg;

    localparam int unsigned RB_ADDR_W = 10;
    localparam int unsigned RB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } rb_init_state_t;

endpackage

// File: rtl/ram_bus_initiator.sv
// APB3-style initiator: turns single request/response transactions into SETUP/ACCESS
// bus cycles, honouring wait states and PSLVERR and aborting hung transfers.
module ram_bus_initiator
    import ram_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = RB_ADDR_W,
    parameter int unsigned DATA_W         = RB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    rb_init_state_t   state;
    logic [CNT_W-1:0] wait_cnt;

    // Only a state decode, so no input reaches an output combinationally.
    assign req_ready = (state == IDLE);

    // paddr/pwrite/pwdata double as the request latch for the whole transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state    <= SETUP;
                        psel     <= 1'b1;
                        paddr    <= req_addr;
                        pwrite   <= req_write;
                        pwdata   <= req_write ? req_wdata : '0;
                        wait_cnt <= '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (TIMEOUT_EN && (wait_cnt == CNT_W'(TIMEOUT_CYCLES))) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        // Saturating, so a disabled timeout never wraps the count.
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
